fsm_control_param: RTL

Parametrised successor of the 5-FIFO flow-control FSM. Supervises NUM_FIFOS FIFOs and holds per-FIFO almost-empty/almost-full thresholds captured during INIT. Reports idle/active/error status to the switch datapath. New versus the fixed version:
- Generic FIFO count and threshold width.
- Debounced idle detection.
- Sticky, accumulating error vector.
- Explicit error-recovery path.

---
 rtl/fsm_control_param.sv | 119 +++++++++++
 1 files changed

// File: rtl/fsm_control_param.sv
// Flow-control supervisor for NUM_FIFOS FIFOs: threshold capture, debounced idle, sticky errors.
// Optional saturating error-entry counter enabled by defining FSM_ERR_COUNT_EN.
module fsm_control_param #(
  parameter int NUM_FIFOS   = 5,
  parameter int TH_W        = 4,
  parameter int IDLE_CYCLES = 4,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      init,
  input  logic [NUM_FIFOS*TH_W-1:0] umbral_in,
  input  logic [NUM_FIFOS-1:0]      fifo_error,
  input  logic [NUM_FIFOS-1:0]      fifo_empty,
  output logic [NUM_FIFOS*TH_W-1:0] umbral_out,
  output logic [2:0]                state,
  output logic                      active,
  output logic                      idle,
  output logic [NUM_FIFOS-1:0]      error_out,
  output logic [ERR_CNT_W-1:0]      err_count
);

  localparam int RUN_W = $clog2(IDLE_CYCLES + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(IDLE_CYCLES);

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  state_t                      state_q, state_d;
  logic [RUN_W-1:0]            run_q, run_d;
  logic [NUM_FIFOS*TH_W-1:0]   umbral_q;
  logic [NUM_FIFOS-1:0]        error_q;
  logic                        any_err;
  logic                        all_empty;
  logic                        enter_error;

  assign any_err     = |fifo_error;
  assign all_empty   = &fifo_empty;
  assign enter_error = (state_d == ST_ERROR) && (state_q != ST_ERROR);

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    run_d   = '0;
    case (state_q)
      ST_RESET: state_d = ST_INIT;
      ST_INIT: begin
        if (!init) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (any_err)         state_d = ST_ERROR;
        else if (init)       state_d = ST_INIT;
        else if (!all_empty) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (any_err)   state_d = ST_ERROR;
        else if (init) state_d = ST_INIT;
        else begin
          // Run length of consecutive all-empty cycles; leaving ACTIVE drops it back to 0.
          if (all_empty) run_d = (run_q == RUN_MAX) ? run_q : run_q + RUN_W'(1);
          if (run_d == RUN_MAX) state_d = ST_IDLE;
        end
      end
      ST_ERROR: begin
        if (init) state_d = ST_INIT;
      end
      default: state_d = ST_RESET;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_RESET;
      run_q    <= '0;
      umbral_q <= '0;
      error_q  <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      if (state_q == ST_INIT) umbral_q <= umbral_in;
      if (state_d == ST_INIT) begin
        error_q <= '0;
      end else if (state_d == ST_ERROR) begin
        error_q <= (state_q == ST_ERROR) ? (error_q | fifo_error) : fifo_error;
      end
    end
  end

`ifdef FSM_ERR_COUNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_cnt_q <= '0;
    end else if (enter_error && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
      err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
    end
  end

  assign err_count = err_cnt_q;
`else
  logic unused_enter_error;
  assign unused_enter_error = enter_error;
  assign err_count          = '0;
`endif

  assign state      = state_q;
  assign active     = (state_q == ST_ACTIVE);
  assign idle       = (state_q == ST_IDLE);
  assign umbral_out = umbral_q;
  assign error_out  = error_q;

endmodule
